// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared types and constants for the forwarding/hazard scoreboard: shadow-entry layout,
// forward-select encoding and the select-width helper.
package fwd_hazard_scoreboard_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  localparam int FWD_RF = 0;

  // One shadow pipeline slot: the destination tag of an in-flight instruction.
  typedef struct packed {
    logic             vld;
    logic             wr;
    logic             load;
    logic [REG_W-1:0] dst;
  } shadow_entry_t;

  // Select width wide enough to encode 0 (register file) through DEPTH.
  function automatic int sw_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_prio_sel.sv
// Per-source priority compare over the shadow pipe: youngest matching producer wins,
// and a load that cannot yet forward flags a load-use hazard.
module fwd_prio_sel
  import fwd_hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int LOAD_RDY = 2,
  parameter int SW       = sw_width(DEPTH)
) (
  input  logic [REG_W-1:0]          src,
  input  shadow_entry_t [DEPTH:1]   ents,
  output logic [SW-1:0]             sel,
  output logic                      load_nr
);

  // NOTE: both outputs get a default before the loop so no path leaves them unassigned (no latch).
  always_comb begin
    sel     = SW'(FWD_RF);
    load_nr = 1'b0;
    // Scan oldest to youngest so the smallest matching k is the last one written.
    for (int k = DEPTH; k >= 1; k--) begin
      if (ents[k].vld && ents[k].wr && (ents[k].dst != REG_ZERO) && (ents[k].dst == src)) begin
        sel     = SW'(k);
        load_nr = ents[k].load && (k < LOAD_RDY);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding/hazard unit for the 5-stage pipeline: shadow tag pipe, registered EX forward
// selects, load-use and mult/div busy stalls.
module fwd_hazard_scoreboard
  import fwd_hazard_scoreboard_pkg::*;
#(
  parameter int N_SRC    = 2,
  parameter int DEPTH    = 2,
  parameter int LOAD_RDY = 2,
  parameter int MD_LAT   = 4,
  parameter int SW       = sw_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ID_Valid,
  input  logic [REG_W*N_SRC-1:0]   ID_Src,
  input  logic [REG_W-1:0]         ID_Dst,
  input  logic                     ID_Wr,
  input  logic                     ID_Load,
  input  logic                     ID_Md_Start,
  input  logic                     ID_Uses_HiLo,
  input  logic                     Flush,
  input  logic                     Hold,
  output logic [SW*N_SRC-1:0]      Fwd_Sel,
  output logic                     Stall,
  output logic                     Md_Busy
);

  localparam int MDW = $clog2(MD_LAT + 1);

  shadow_entry_t [DEPTH:1] shadow;
  logic [MDW-1:0]          md_cnt;
  logic [SW*N_SRC-1:0]     sel_next;
  logic [N_SRC-1:0]        load_nr;
  logic                    md_hazard;
  logic                    kill;
  logic                    issue;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    fwd_prio_sel #(
      .DEPTH    (DEPTH),
      .LOAD_RDY (LOAD_RDY),
      .SW       (SW)
    ) u_sel (
      .src     (ID_Src[REG_W*i +: REG_W]),
      .ents    (shadow),
      .sel     (sel_next[SW*i +: SW]),
      .load_nr (load_nr[i])
    );
  end

  assign Md_Busy   = (md_cnt != '0);
  assign md_hazard = (ID_Md_Start || ID_Uses_HiLo) && Md_Busy;
  assign Stall     = ID_Valid && !Flush && ((|load_nr) || md_hazard);
  // A flushed or stalled slot enters EX as a bubble and never starts the mult/div counter.
  assign kill      = Flush || Stall;
  assign issue     = ID_Valid && !kill;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      Fwd_Sel <= '0;
      md_cnt  <= '0;
    end else if (!Hold) begin
      for (int k = DEPTH; k >= 2; k--) begin
        shadow[k] <= shadow[k-1];
      end
      if (kill) begin
        shadow[1] <= '0;
        Fwd_Sel   <= '0;
      end else begin
        shadow[1] <= shadow_entry_t'{vld: ID_Valid, wr: ID_Wr, load: ID_Load, dst: ID_Dst};
        Fwd_Sel   <= ID_Valid ? sel_next : '0;
      end
      if (issue && ID_Md_Start) begin
        md_cnt <= MDW'(MD_LAT);
      end else if (md_cnt != '0) begin
        md_cnt <= md_cnt - 1'b1;
      end
    end
  end

endmodule
